// File: rtl/siso_tx_ctrl.sv
// rtl/siso_tx_ctrl.sv - parallel-to-serial frame controller feeding a SISO shift chain
//
// Accepts a WIDTH-bit word under a ready/start handshake and presents it one
// bit per clock on ser_out with a ser_valid qualifier. A one-cycle done pulse
// follows the last bit of a completed frame. All outputs are registered.
//
// Ports:
//   clk       in   1      single clock, rising edge
//   rst       in   1      synchronous active-low reset
//   start     in   1      transmit request, honoured only while ready=1
//   par_in    in   WIDTH  parallel word, captured on the accept edge
//   abort     in   1      terminates the frame, honoured only while shifting
//   ready     out  1      idle, able to accept start
//   busy      out  1      frame in progress (complement of ready)
//   ser_out   out  1      serial data bit
//   ser_valid out  1      ser_out carries a frame bit
//   done      out  1      one-cycle pulse after the last bit of a completed frame
//   bit_cnt   out  CW     bits already emitted in the current frame

module siso_tx_ctrl #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] par_in,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             ser_out_n;
  logic             ser_valid_n;
  logic             done_n;
  logic             ready_n;
  logic [CW-1:0]    bit_cnt_n;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  // Bit to transmit next from a word, honouring the bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  // Word with the transmitted bit removed, next bit moved to the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      done      <= done_n;
      ready     <= ready_n;
      busy      <= !ready_n;
      bit_cnt   <= bit_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    ser_out_n   = 1'b0;
    ser_valid_n = 1'b0;
    done_n      = 1'b0;
    bit_cnt_n   = bit_cnt;

    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        if (start) begin
          // The first bit leaves on the accept edge itself, so the register
          // keeps the word already advanced past that bit.
          state_n     = SHIFT;
          ser_out_n   = head_bit(par_in);
          shreg_n     = advance(par_in);
          ser_valid_n = 1'b1;
          bit_cnt_n   = CW'(1);
        end
      end

      SHIFT: begin
        if (abort) begin
          // Abort wins even on the final edge: no done for this frame.
          state_n   = IDLE;
          bit_cnt_n = '0;
        end else if (bit_cnt == LAST_CNT) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          ser_out_n   = head_bit(shreg);
          shreg_n     = advance(shreg);
          ser_valid_n = 1'b1;
          bit_cnt_n   = bit_cnt + CW'(1);
        end
      end

      DONE: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
      end

      default: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
      end
    endcase

    ready_n = (state_n == IDLE);
  end

endmodule
